// File: rtl/my_pkg.sv
// my_pkg: shared types for the retire stage.
//   iType_e          decoded operation seen at retire
//   exceptionCode_e  mcause-style exception codes (NE = no exception)
//   sb_entry_t       one store-buffer entry {address, data, byte strobes}
package my_pkg;

  localparam int unsigned DEFAULT_TAG_WIDTH = 3;
  localparam int unsigned XLEN              = 32;

  typedef enum logic [5:0] {
    NOP, LUI, ADD, SUB, SLTU, SLT, XOR, OR, AND, SLL, SRL, SRA,
    LB, LBU, LH, LHU, LW, SB, SH, SW,
    BEQ, BNE, BLT, BLTU, BGE, BGEU, JAL, JALR,
    ECALL, EBREAK, MRET, WFI, FENCE, CSRRW, CSRRS, CSRRC, INVALID
  } iType_e;

  typedef enum logic [5:0] {
    INSTRUCTION_ADDRESS_MISALIGNED = 6'h00,
    ILLEGAL_INSTRUCTION            = 6'h02,
    BREAKPOINT                     = 6'h03,
    ECALL_FROM_MMODE               = 6'h0B,
    NE                             = 6'h3F
  } exceptionCode_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [3:0]      strb;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of retired stores waiting to drain to memory.
//   push/push_entry  enqueue (accepted when not full, or when full and popping)
//   pop              dequeue head (ignored when empty)
//   head             current head entry, stable until popped
//   full/empty       occupancy flags
//   match_word/match word-address query against every valid entry
module store_buffer
  import my_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  sb_entry_t   push_entry,
  input  logic        pop,
  output sb_entry_t   head,
  output logic        full,
  output logic        empty,
  input  logic [29:0] match_word,
  output logic        match
);

  localparam int unsigned IW = $clog2(SB_DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [IW-1:0]       wr_idx, rd_idx;
  logic [SB_DEPTH-1:0] valid_q;
  sb_entry_t           mem [SB_DEPTH];
  logic                do_push, do_pop;

  assign wr_idx  = wr_ptr[IW-1:0];
  assign rd_idx  = rd_ptr[IW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_idx];

  // Pointers and per-slot valid bits; a push into the slot being popped wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        valid_q[rd_idx] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Entry storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_entry;
  end

  // Word-address hit against any occupied slot.
  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (valid_q[IW'(i)] && (mem[IW'(i)].addr[31:2] == match_word)) match = 1'b1;
    end
  end

endmodule

// File: rtl/retire_sb.sv
// retire_sb: retire stage with a post-retirement store buffer.
//   Inputs : retiring instruction (valid_i, tag_i, operation, results, flags),
//            load data, memory grant for the store-drain port.
//   Outputs: stall/kill, register write, jump redirect, exception/MRET/IRQ ack,
//            store-drain request (mem_*), current tag, retired-instruction count.
// Stores are written to the buffer at retire and drained in order via mem_req_o/
// mem_gnt_i; loads that alias a buffered word stall until that entry drains.
module retire_sb
  import my_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = DEFAULT_TAG_WIDTH,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_i,
  input  logic [31:0]          instruction_i,
  input  logic [31:0]          pc_i,
  input  logic [1:0][31:0]     results_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  iType_e               instruction_operation_i,
  input  logic                 write_enable_i,
  input  logic                 jump_i,
  input  logic [3:0]           mem_write_enable_i,
  input  logic                 exc_ilegal_inst_i,
  input  logic                 exc_misaligned_fetch_i,
  input  logic                 interrupt_pending_i,
  input  logic [31:0]          mem_data_i,
  output logic                 stall_o,
  output logic                 regbank_write_enable_o,
  output logic [31:0]          regbank_data_o,
  output logic                 jump_o,
  output logic [31:0]          jump_target_o,
  output logic                 killed_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [31:0]          mem_write_address_o,
  output logic [31:0]          mem_data_o,
  output logic [3:0]           mem_write_enable_o,
  output logic [TAG_WIDTH-1:0] current_retire_tag_o,
  output logic                 raise_exception_o,
  output exceptionCode_e       exception_code_o,
  output logic                 machine_return_o,
  output logic                 interrupt_ack_o,
  output logic [63:0]          instret_o
);

  logic [TAG_WIDTH-1:0] tag_q;
  logic [63:0]          instret_q;
  logic                 is_store, is_load, live, accepted, exc_hit, tag_advance;
  logic                 sb_full, sb_empty, sb_match, sb_pop, sb_push;
  exceptionCode_e       exc_code;
  sb_entry_t            sb_head, sb_in;
  logic [31:0]          byte_word, half_word;
  logic                 unused_sig;

  assign unused_sig = ^{instruction_i, pc_i};

  assign is_store = (instruction_operation_i inside {SB, SH, SW}) && (|mem_write_enable_i);
  assign is_load  = instruction_operation_i inside {LB, LBU, LH, LHU, LW};

  assign killed_o  = valid_i && (tag_i != tag_q);
  assign live      = valid_i && !killed_o;
  assign mem_req_o = !sb_empty;
  assign sb_pop    = mem_req_o && mem_gnt_i;

  // A full buffer only blocks a store when no slot frees up this cycle.
  assign stall_o = live && ((is_store && sb_full && !sb_pop)
                         || (is_load && sb_match)
                         || ((instruction_operation_i == FENCE) && !sb_empty));
  assign accepted = live && !stall_o;

  // Synchronous exceptions in priority order.
  always_comb begin
    exc_hit  = 1'b0;
    exc_code = NE;
    if (exc_ilegal_inst_i) begin
      exc_hit  = 1'b1;
      exc_code = ILLEGAL_INSTRUCTION;
    end else if (exc_misaligned_fetch_i) begin
      exc_hit  = 1'b1;
      exc_code = INSTRUCTION_ADDRESS_MISALIGNED;
    end else if (instruction_operation_i == ECALL) begin
      exc_hit  = 1'b1;
      exc_code = ECALL_FROM_MMODE;
    end else if (instruction_operation_i == EBREAK) begin
      exc_hit  = 1'b1;
      exc_code = BREAKPOINT;
    end
  end

  assign raise_exception_o      = accepted && exc_hit;
  assign exception_code_o       = raise_exception_o ? exc_code : NE;
  assign machine_return_o       = accepted && !exc_hit && (instruction_operation_i == MRET);
  assign interrupt_ack_o        = accepted && !exc_hit && (instruction_operation_i != MRET)
                                  && interrupt_pending_i;
  assign jump_o                 = accepted && !exc_hit && jump_i;
  assign jump_target_o          = results_i[1];
  assign regbank_write_enable_o = accepted && !exc_hit && write_enable_i;
  assign sb_push                = accepted && !exc_hit && is_store;
  assign tag_advance            = jump_o || raise_exception_o || machine_return_o
                                  || interrupt_ack_o;

  // Load alignment: shift the addressed byte/half down to bit 0.
  assign byte_word = mem_data_i >> {results_i[0][1:0], 3'b000};
  assign half_word = mem_data_i >> {results_i[0][1], 4'b0000};

  always_comb begin
    regbank_data_o = results_i[0];
    case (instruction_operation_i)
      LB:      regbank_data_o = {{24{byte_word[7]}}, byte_word[7:0]};
      LBU:     regbank_data_o = {24'h000000, byte_word[7:0]};
      LH:      regbank_data_o = {{16{half_word[15]}}, half_word[15:0]};
      LHU:     regbank_data_o = {16'h0000, half_word[15:0]};
      LW:      regbank_data_o = mem_data_i;
      default: regbank_data_o = results_i[0];
    endcase
  end

  assign sb_in = '{addr: results_i[0], data: results_i[1], strb: mem_write_enable_i};

  store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (sb_push),
    .push_entry (sb_in),
    .pop        (sb_pop),
    .head       (sb_head),
    .full       (sb_full),
    .empty      (sb_empty),
    .match_word (results_i[0][31:2]),
    .match      (sb_match)
  );

  assign mem_write_address_o = sb_head.addr;
  assign mem_data_o          = sb_head.data;
  assign mem_write_enable_o  = sb_head.strb;

  // Retire tag and retired-instruction counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q     <= '0;
      instret_q <= '0;
    end else begin
      if (tag_advance) tag_q <= tag_q + TAG_WIDTH'(1);
      if (accepted)    instret_q <= instret_q + 64'd1;
    end
  end

  assign current_retire_tag_o = tag_q;
  assign instret_o            = instret_q;

endmodule
